pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath, the next generation of the fixed IF/ID latch. It carries `LANES` independent `DATA_W`-bit fields, for example instruction and PC+4, between two pipeline stages. Flow control uses a valid/ready handshake backed by a 2-entry skid buffer, so `in_ready` is a registered signal. It also supports an external stall, a flush that takes priority over everything else, and optional performance counters. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 160 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised pipeline stage register placed between two datapath stages
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries LANES independent DATA_W-bit
//   fields, with lane 0 in the LSBs. A valid/ready handshake is backed by a
//   2-entry skid buffer, so in_ready is a registered signal. Flush discards
//   all stored entries and overrides every other control input. Stall holds
//   the output entry.
//
//   Optional feature macro: PIPE_STAGE_PERF_EN
//     defined   -> saturating stall/flush performance counters are built
//     undefined -> stall_cnt and flush_cnt are tied to 0
//
// Parameters
//   DATA_W     : width of one lane
//   LANES      : number of lanes
//   FLUSH_ZERO : 1 = flush also zeroes stored data (lane 0 reads as NOP)
//   CNT_W      : performance counter width
//
// Ports
//   CLK        in  rising-edge clock
//   RST_N      in  asynchronous active-low reset
//   Flush      in  discard all stored entries
//   Stall      in  downstream stage blocked; hold output
//   in_valid   in  upstream has data
//   in_data    in  upstream data (LANES*DATA_W)
//   in_ready   out stage can accept data (registered)
//   out_valid  out out_data is valid (registered)
//   out_data   out main entry contents (registered)
//   out_ready  in  downstream can accept data
//   stall_cnt  out cycles with a valid but blocked output
//   flush_cnt  out cycles with Flush asserted
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANES      = 2,
  parameter int unsigned FLUSH_ZERO = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      Flush,
  input  logic                      Stall,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int unsigned W = LANES * DATA_W;

  // EMPTY: M and S invalid; ONE: only M valid; FULL: M and S valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   skid_data;

  logic           acc_in;
  logic           acc_out;

  // Handshake qualifiers; Stall masks the downstream side only.
  assign acc_in  = in_valid & in_ready;
  assign acc_out = out_valid & out_ready & ~Stall;

  // Storage and state. Every output is updated here so all are registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
    end else if (Flush) begin
      // Flush overrides accept, drain and Stall; flush-cycle input is dropped.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      if (FLUSH_ZERO != 0) begin
        out_data  <= '0;
        skid_data <= '0;
      end
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (acc_in) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        end

        ST_ONE: begin
          if (acc_in && acc_out) begin
            // Sustained streaming: replace M in place.
            out_data <= in_data;
          end else if (acc_in) begin
            // M blocked: park the newer word in S and close the input.
            skid_data <= in_data;
            in_ready  <= 1'b0;
            state     <= ST_FULL;
          end else if (acc_out) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only a drain can happen; S moves to M.
          if (acc_out) begin
            out_data <= skid_data;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        end

        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic stall_evt;

  // A valid output that did not transfer this cycle.
  assign stall_evt = out_valid & ~(out_ready & ~Stall);

  // Saturating counters; only reset clears them, Flush does not.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (Flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed self-checking bench for pipe_stage_reg (DATA_W=32, LANES=2,
//   FLUSH_ZERO=1, CNT_W=4). Inputs change and outputs are sampled 1 ns after
//   each rising CLK edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 2;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned W      = DATA_W * LANES;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             Flush;
  logic             Stall;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int tests = 0;
  int fails = 0;

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .LANES     (LANES),
    .FLUSH_ZERO(1),
    .CNT_W     (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Flush    (Flush),
    .Stall    (Stall),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; Flush = 1'b0; Stall = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #13;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 64'h0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [W-1:0] vec [3];
    vec[0] = {32'h0000_1004, 32'h11};
    vec[1] = {32'h0000_1008, 32'h22};
    vec[2] = {32'h0000_100C, 32'h33};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      step();
      tests++; if (out_valid !== 1'b1 || out_data !== vec[i]) begin
        fails++; $display("FAIL stream_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, vec[i]);
      end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready_%0d got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'hA;
    step();                                   // ONE holding A
    Stall = 1'b1; in_data = 64'hB;
    step();                                   // B into skid, FULL
    tests++; if (in_ready !== 1'b0 || out_data !== 64'hA) begin
      fails++; $display("FAIL skid_fill got rdy=%b d=%h want rdy=0 d=a", in_ready, out_data);
    end
    in_data = 64'hC;
    step();                                   // C held upstream
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 64'hA) begin
      fails++; $display("FAIL skid_hold got rdy=%b v=%b d=%h want 0/1/a", in_ready, out_valid, out_data);
    end
    Stall = 1'b0;
    step();                                   // S->M; C not yet accepted
    tests++; if (out_data !== 64'hB || in_ready !== 1'b1) begin
      fails++; $display("FAIL skid_order_b got d=%h rdy=%b want b/1", out_data, in_ready);
    end
    step();                                   // C accepted and drained
    tests++; if (out_valid !== 1'b1 || out_data !== 64'hC) begin
      fails++; $display("FAIL skid_order_c got v=%b d=%h want 1/c", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL skid_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1;
    step();
    in_data = 64'h2;
    step();                                   // FULL
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_full got rdy=%b want 0", in_ready); end
    Flush = 1'b1; in_data = 64'h3;
    step();
    tests++; if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_full got v=%b d=%h rdy=%b want 0/0/1", out_valid, out_data, in_ready);
    end
    Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_lost got v=%b want 0", out_valid); end
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h5;
    step();                                   // ONE
    Flush = 1'b1; Stall = 1'b1; in_valid = 1'b0;
    step();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0) begin
      fails++; $display("FAIL flush_stall got v=%b rdy=%b d=%h want 0/1/0", out_valid, in_ready, out_data);
    end
    Flush = 1'b0; Stall = 1'b0; in_valid = 1'b1; in_data = 64'h6;
    step();                                   // EMPTY behaviour: 1-cycle latency
    tests++; if (out_valid !== 1'b1 || out_data !== 64'h6) begin
      fails++; $display("FAIL flush_stall_empty got v=%b d=%h want 1/6", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h7;
    step();
    in_data = 64'h8;
    step();                                   // FULL
    in_valid = 1'b0;
    #2 RST_N = 1'b0;                          // mid-cycle, no clock edge
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset got v=%b d=%h rdy=%b want 0/0/1", out_valid, out_data, in_ready);
    end
    #3 RST_N = 1'b1;                          // release before next edge
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h9;
    step();
    tests++; if (out_valid !== 1'b1 || out_data !== 64'h9) begin
      fails++; $display("FAIL async_reset_after got v=%b d=%h want 1/9", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
`ifdef PIPE_STAGE_PERF_EN
    exp_stall = 4'd15;
    exp_flush = 4'd3;
`else
    exp_stall = 4'd0;
    exp_flush = 4'd0;
`endif
    #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    out_ready = 1'b1; Stall = 1'b1; in_valid = 1'b1; in_data = 64'h1;
    step();                                   // accepted, out_valid=1
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();      // 20 stalled cycles
    tests++; if (stall_cnt !== exp_stall) begin
      fails++; $display("FAIL perf_stall got %0d want %0d", stall_cnt, exp_stall);
    end
    Stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Flush = 1'b1; step();
      Flush = 1'b0; step();
    end
    tests++; if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
      fails++; $display("FAIL perf_flush got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush_full();
    test_flush_stall();
    test_async_reset();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
